// File: rtl/des_decrypt_key_sched.sv
// DES decryption-order key schedule.
// Streams K16 down to K1 over a valid/ready interface. Each subkey comes from
// right rotations of the C/D halves, so no subkey store is needed.
module des_decrypt_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_idx,
    output logic        subkey_last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // PC-1: 1-based DES key bit numbers, bit 1 = key[63]
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: 1-based positions in the 56-bit {C, D}, position 1 = MSB of C
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_reg;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic [3:0]  cnt_reg;

    logic [55:0] pc1_key;
    logic [55:0] cd_cur;
    logic [47:0] pc2_out;
    logic        single_step;
    logic [27:0] c_next;
    logic [27:0] d_next;
    logic        unused_parity;

    // Parity bits (DES bits 8, 16, ..., 64) take no part in the schedule
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    genvar gi;

    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[55-gi] = key[64-PC1_TAB[gi]];
        end
    endgenerate

    assign cd_cur = {c_reg, d_reg};

    generate
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            assign pc2_out[47-gi] = cd_cur[56-PC2_TAB[gi]];
        end
    endgenerate

    // Reversed encrypt shift schedule: outputs 1, 8 and 15 step by one, the rest by two
    assign single_step = (cnt_reg == 4'd0) || (cnt_reg == 4'd7) || (cnt_reg == 4'd14);
    assign c_next = single_step ? {c_reg[0], c_reg[27:1]} : {c_reg[1:0], c_reg[27:2]};
    assign d_next = single_step ? {d_reg[0], d_reg[27:1]} : {d_reg[1:0], d_reg[27:2]};

    // Schedule FSM: load PC-1 on start, rotate right on each accepted subkey
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        c_reg     <= pc1_key[55:28];
                        d_reg     <= pc1_key[27:0];
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (subkey_ready) begin
                        if (cnt_reg == 4'd15) begin
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                            c_reg   <= c_next;
                            d_reg   <= d_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; data is zeroed when not valid
    always_comb begin
        busy         = (state_reg == RUN);
        subkey_valid = (state_reg == RUN);
        subkey       = subkey_valid ? pc2_out : 48'h0;
        subkey_idx   = subkey_valid ? (4'd15 - cnt_reg) : 4'd0;
        subkey_last  = subkey_valid && (cnt_reg == 4'd15);
    end

endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// Bench for des_decrypt_key_sched: a transaction-level model of the
// decrypt-order stream, built from a left-shift encrypt-order subkey generator.
module tb_des_decrypt_key_sched;

    localparam logic [63:0] KV      = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR_MSK = 64'h0101010101010101;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] key;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_idx;
    logic        subkey_last;

    int checks   = 0;
    int failures = 0;

    des_decrypt_key_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key          (key),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_idx   (subkey_idx),
        .subkey_last  (subkey_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Textbook encrypt-order generator: cumulative LEFT shifts, round 1..16
    function automatic logic [47:0] enc_subkey(input logic [63:0] k, input int round);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] r;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < round; n++) begin
            for (int s = 0; s < SHIFT_T[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
        return r;
    endfunction

    // Transaction model: which output of which key should be on the port
    logic        m_active = 1'b0;
    int          m_pos    = 0;
    logic [63:0] m_key    = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_pos    <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_pos    <= 0;
                m_key    <= key;
            end
        end else if (subkey_ready) begin
            if (m_pos == 15) m_active <= 1'b0;
            else m_pos <= m_pos + 1;
        end
    end

    // Compare process: every cycle, mid-period
    logic        cmp_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [51:0] stall_val;
    logic [51:0] hs_log[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [47:0] exp_sk;
            exp_sk = m_active ? enc_subkey(m_key, 16 - m_pos) : 48'h0;
            chk("valid", {63'h0, subkey_valid}, {63'h0, m_active});
            chk("busy", {63'h0, busy}, {63'h0, m_active});
            chk("subkey", {16'h0, subkey}, {16'h0, exp_sk});
            chk("idx", {60'h0, subkey_idx}, m_active ? 64'(15 - m_pos) : 64'h0);
            chk("last", {63'h0, subkey_last}, {63'h0, m_active && (m_pos == 15)});
            if (stall_prev) chk("stall_hold", {12'h0, subkey_idx, subkey}, {12'h0, stall_val});
            stall_prev = rst_n && subkey_valid && !subkey_ready;
            stall_val  = {subkey_idx, subkey};
            if (rst_n && subkey_valid && subkey_ready) begin
                hs_log.push_back({subkey_idx, subkey});
                $display("HS idx=%0d subkey=%h last=%0d", subkey_idx, subkey, subkey_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one schedule and drain it; returns number of valid cycles seen
    task automatic run_sched(input logic [63:0] k, input bit rnd, output int vcycles);
        int budget;
        hs_log.delete();
        key = k;
        start = 1'b1;
        subkey_ready = 1'b1;
        tick();
        start = 1'b0;
        key = ~k;
        budget = 0;
        vcycles = 0;
        while (subkey_valid && budget < 400) begin
            subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            vcycles++;
            tick();
            budget++;
        end
        chk("run_timeout", 64'(budget >= 400), 64'h0);
        subkey_ready = 1'b1;
    endtask

    task automatic check_log(input logic [63:0] k, input string tag);
        chk({tag, "_count"}, 64'(hs_log.size()), 64'd16);
        for (int i = 0; i < hs_log.size(); i++) begin
            chk({tag, "_idx"}, {60'h0, hs_log[i][51:48]}, 64'(15 - i));
            chk({tag, "_key"}, {16'h0, hs_log[i][47:0]}, {16'h0, enc_subkey(k, 16 - i)});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int          vc;
        int          hs;
        int          budget;
        logic        last_hs;
        logic [63:0] rk;
        logic [63:0] ka;
        logic [63:0] kb;
        logic [51:0] log_a[$];

        // Reset with start held high: reset must win
        rst_n = 1'b0;
        start = 1'b1;
        key = KV;
        subkey_ready = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_valid", {63'h0, subkey_valid}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_subkey", {16'h0, subkey}, 64'h0);
        chk("rst_idx", {60'h0, subkey_idx}, 64'h0);
        chk("rst_last", {63'h0, subkey_last}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Pin the model against published DES subkeys
        chk("model_K16", {16'h0, enc_subkey(KV, 16)}, 64'h0000CB3D8B0E17F5);
        chk("model_K15", {16'h0, enc_subkey(KV, 15)}, 64'h0000BF918D3D3F0A);
        chk("model_K1", {16'h0, enc_subkey(KV, 1)}, 64'h00001B02EFFC7072);

        // Known vector, ready always high
        run_sched(KV, 1'b0, vc);
        chk("kv_valid_cycles", 64'(vc), 64'd16);
        chk("kv_count", 64'(hs_log.size()), 64'd16);
        if (hs_log.size() == 16) begin
            chk("kv_first", {12'h0, hs_log[0]}, {12'h0, 4'd15, 48'hCB3D8B0E17F5});
            chk("kv_second", {12'h0, hs_log[1]}, {12'h0, 4'd14, 48'hBF918D3D3F0A});
            chk("kv_sixteenth", {12'h0, hs_log[15]}, {12'h0, 4'd0, 48'h1B02EFFC7072});
        end
        chk("kv_idle_after", {63'h0, busy}, 64'h0);

        // Random keys against the encrypt-order generator reversed
        for (int r = 0; r < 4; r++) begin
            rk = {$urandom, $urandom};
            run_sched(rk, 1'b0, vc);
            check_log(rk, "rand");
        end

        // Backpressure: 50% ready
        run_sched(KV, 1'b1, vc);
        check_log(KV, "bp_kv");
        for (int r = 0; r < 2; r++) begin
            rk = {$urandom, $urandom};
            run_sched(rk, 1'b1, vc);
            check_log(rk, "bp_rand");
        end

        // Start while busy is ignored; start right after the last handshake is taken
        ka = {$urandom, $urandom};
        kb = ka ^ 64'hFFFF0000FFFF0000;
        hs_log.delete();
        key = ka;
        start = 1'b1;
        tick();
        start = 1'b0;
        hs = 0;
        budget = 0;
        last_hs = 1'b0;
        while (subkey_valid && budget < 100 && !last_hs) begin
            start = (hs == 5) && (budget == 5);
            key = start ? kb : ka;
            last_hs = subkey_valid && subkey_ready && subkey_last;
            if (subkey_valid && subkey_ready) hs++;
            tick();
            budget++;
        end
        chk("busy_start_timeout", 64'(budget >= 100), 64'h0);
        check_log(ka, "busy_start");
        key = kb;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_valid", {63'h0, subkey_valid}, 64'h1);
        chk("b2b_idx", {60'h0, subkey_idx}, 64'd15);
        chk("b2b_K16", {16'h0, subkey}, {16'h0, enc_subkey(kb, 16)});
        budget = 0;
        while (subkey_valid && budget < 100) begin
            tick();
            budget++;
        end
        chk("b2b_drain", 64'(budget), 64'd16);

        // Reset mid-schedule at cnt = 8
        key = KV;
        start = 1'b1;
        tick();
        start = 1'b0;
        hs = 0;
        budget = 0;
        while (hs < 8 && budget < 100) begin
            if (subkey_valid && subkey_ready) hs++;
            tick();
            budget++;
        end
        chk("mid_idx_before_reset", {60'h0, subkey_idx}, 64'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", {63'h0, subkey_valid}, 64'h0);
        chk("mid_rst_busy", {63'h0, busy}, 64'h0);
        chk("mid_rst_subkey", {16'h0, subkey}, 64'h0);
        tick();
        run_sched(ka, 1'b0, vc);
        check_log(ka, "after_rst");

        // Parity bits must not matter
        run_sched(KV, 1'b0, vc);
        log_a = hs_log;
        run_sched(KV ^ PAR_MSK, 1'b0, vc);
        chk("par_count", 64'(hs_log.size()), 64'(log_a.size()));
        for (int i = 0; i < hs_log.size() && i < log_a.size(); i++)
            chk("par_key", {12'h0, hs_log[i]}, {12'h0, log_a[i]});

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
